// File: rtl/bp_common_aviary_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_common_aviary_pkg
// Description : Processor parameter struct, config table and field accessors.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_common_aviary_pkg;

    localparam int unsigned num_cfg_fields_gp          = 41;
    localparam int unsigned bp_cfg_field_idx_width_gp  = 6;
    localparam int unsigned bp_cfg_max_field_width_gp  = 16;

    typedef struct packed {
        logic [15:0] cc_x_dim, cc_y_dim, ic_x_dim, ic_y_dim, mc_x_dim, mc_y_dim;
        logic [15:0] cac_x_dim, sac_x_dim, cacc_type, sacc_type, num_cce, num_lce;
        logic [15:0] vaddr_width, paddr_width, asid_width, branch_metadata_fwd_width;
        logic [15:0] btb_tag_width, btb_idx_width, bht_idx_width, ghist_width;
        logic [15:0] d_lce_assoc, lce_sets, cce_block_width, num_cce_instr_ram_els, l2_assoc;
        logic        async_coh_clk;
        logic [15:0] coh_noc_max_credits, coh_noc_flit_width, coh_noc_cid_width, coh_noc_len_width;
        logic        async_mem_clk;
        logic [15:0] mem_noc_max_credits, mem_noc_flit_width, mem_noc_cid_width, mem_noc_len_width;
        logic        async_io_clk;
        logic [15:0] io_noc_max_credits, io_noc_flit_width, io_noc_cid_width, io_noc_did_width,
                     io_noc_len_width;
    } bp_proc_param_s;

    typedef enum logic [5:0] {
        e_cc_x_dim, e_cc_y_dim, e_ic_x_dim, e_ic_y_dim, e_mc_x_dim, e_mc_y_dim,
        e_cac_x_dim, e_sac_x_dim, e_cacc_type, e_sacc_type, e_num_cce, e_num_lce,
        e_vaddr_width, e_paddr_width, e_asid_width, e_branch_metadata_fwd_width,
        e_btb_tag_width, e_btb_idx_width, e_bht_idx_width, e_ghist_width,
        e_d_lce_assoc, e_lce_sets, e_cce_block_width, e_num_cce_instr_ram_els, e_l2_assoc,
        e_async_coh_clk,
        e_coh_noc_max_credits, e_coh_noc_flit_width, e_coh_noc_cid_width, e_coh_noc_len_width,
        e_async_mem_clk,
        e_mem_noc_max_credits, e_mem_noc_flit_width, e_mem_noc_cid_width, e_mem_noc_len_width,
        e_async_io_clk,
        e_io_noc_max_credits, e_io_noc_flit_width, e_io_noc_cid_width, e_io_noc_did_width,
        e_io_noc_len_width
    } bp_cfg_field_e;

    // Every config starts from the single-core default and overrides a few fields.
    function automatic bp_proc_param_s bp_cfg_lookup(input int unsigned id);
        bp_proc_param_s p;
        p = '0;
        p.cc_x_dim = 16'd1;              p.cc_y_dim = 16'd1;
        p.ic_x_dim = 16'd1;              p.ic_y_dim = 16'd1;
        p.num_cce = 16'd1;               p.num_lce = 16'd2;
        p.vaddr_width = 16'd39;          p.paddr_width = 16'd40;
        p.asid_width = 16'd10;           p.branch_metadata_fwd_width = 16'd39;
        p.btb_tag_width = 16'd10;        p.btb_idx_width = 16'd6;
        p.bht_idx_width = 16'd9;         p.ghist_width = 16'd2;
        p.d_lce_assoc = 16'd8;           p.lce_sets = 16'd64;
        p.cce_block_width = 16'd512;     p.num_cce_instr_ram_els = 16'd256;
        p.l2_assoc = 16'd8;
        p.coh_noc_max_credits = 16'd8;   p.coh_noc_flit_width = 16'd128;
        p.coh_noc_cid_width = 16'd2;     p.coh_noc_len_width = 16'd3;
        p.mem_noc_max_credits = 16'd32;  p.mem_noc_flit_width = 16'd64;
        p.mem_noc_cid_width = 16'd2;     p.mem_noc_len_width = 16'd4;
        p.io_noc_max_credits = 16'd16;   p.io_noc_flit_width = 16'd64;
        p.io_noc_cid_width = 16'd2;      p.io_noc_did_width = 16'd3;
        p.io_noc_len_width = 16'd4;
        case (id)
            2: p.d_lce_assoc = 16'd4;
            3: begin p.cc_x_dim = 16'd2; p.num_lce = 16'd4; p.io_noc_did_width = 16'd2; end
            4: begin
                p.cc_x_dim = 16'd2; p.cc_y_dim = 16'd2; p.num_cce = 16'd4; p.num_lce = 16'd8;
            end
            5: begin p.async_coh_clk = 1'b1; p.async_mem_clk = 1'b1; end
            6: begin p.l2_assoc = 16'd16; p.cce_block_width = 16'd256; end
            7: begin p.vaddr_width = 16'd48; p.paddr_width = 16'd56; end
            8: begin
                p.cc_x_dim = 16'd4; p.cc_y_dim = 16'd4; p.num_cce = 16'd16; p.num_lce = 16'd32;
            end
            9: begin
                p.cc_x_dim = 16'd2; p.cc_y_dim = 16'd4; p.num_cce = 16'd8; p.num_lce = 16'd16;
                p.io_noc_did_width = 16'd1;
            end
            default: ;
        endcase
        return p;
    endfunction

    function automatic logic [bp_cfg_max_field_width_gp-1:0] bp_cfg_field_get(
        input bp_proc_param_s                         p,
        input logic [bp_cfg_field_idx_width_gp-1:0]   field
    );
        logic [bp_cfg_max_field_width_gp-1:0] v;
        v = '0;
        case (bp_cfg_field_e'(field))
            e_cc_x_dim:                  v = p.cc_x_dim;
            e_cc_y_dim:                  v = p.cc_y_dim;
            e_ic_x_dim:                  v = p.ic_x_dim;
            e_ic_y_dim:                  v = p.ic_y_dim;
            e_mc_x_dim:                  v = p.mc_x_dim;
            e_mc_y_dim:                  v = p.mc_y_dim;
            e_cac_x_dim:                 v = p.cac_x_dim;
            e_sac_x_dim:                 v = p.sac_x_dim;
            e_cacc_type:                 v = p.cacc_type;
            e_sacc_type:                 v = p.sacc_type;
            e_num_cce:                   v = p.num_cce;
            e_num_lce:                   v = p.num_lce;
            e_vaddr_width:               v = p.vaddr_width;
            e_paddr_width:               v = p.paddr_width;
            e_asid_width:                v = p.asid_width;
            e_branch_metadata_fwd_width: v = p.branch_metadata_fwd_width;
            e_btb_tag_width:             v = p.btb_tag_width;
            e_btb_idx_width:             v = p.btb_idx_width;
            e_bht_idx_width:             v = p.bht_idx_width;
            e_ghist_width:               v = p.ghist_width;
            e_d_lce_assoc:               v = p.d_lce_assoc;
            e_lce_sets:                  v = p.lce_sets;
            e_cce_block_width:           v = p.cce_block_width;
            e_num_cce_instr_ram_els:     v = p.num_cce_instr_ram_els;
            e_l2_assoc:                  v = p.l2_assoc;
            e_async_coh_clk:             v = 16'(p.async_coh_clk);
            e_coh_noc_max_credits:       v = p.coh_noc_max_credits;
            e_coh_noc_flit_width:        v = p.coh_noc_flit_width;
            e_coh_noc_cid_width:         v = p.coh_noc_cid_width;
            e_coh_noc_len_width:         v = p.coh_noc_len_width;
            e_async_mem_clk:             v = 16'(p.async_mem_clk);
            e_mem_noc_max_credits:       v = p.mem_noc_max_credits;
            e_mem_noc_flit_width:        v = p.mem_noc_flit_width;
            e_mem_noc_cid_width:         v = p.mem_noc_cid_width;
            e_mem_noc_len_width:         v = p.mem_noc_len_width;
            e_async_io_clk:              v = 16'(p.async_io_clk);
            e_io_noc_max_credits:        v = p.io_noc_max_credits;
            e_io_noc_flit_width:         v = p.io_noc_flit_width;
            e_io_noc_cid_width:          v = p.io_noc_cid_width;
            e_io_noc_did_width:          v = p.io_noc_did_width;
            e_io_noc_len_width:          v = p.io_noc_len_width;
            default:                     v = '0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_cfg_field_mux.sv
`default_nettype none
// ============================================================================
// Module      : bp_cfg_field_mux
// Description : Combinational config/field select with range checking.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_cfg_field_mux
    import bp_common_aviary_pkg::*;
#(
    parameter int unsigned num_cfgs_p        = 10,
    parameter int unsigned num_fields_p      = 41,
    parameter int unsigned lg_max_cfgs_p     = 7,
    parameter int unsigned field_idx_width_p = 6,
    parameter int unsigned data_width_p      = 32
) (
    input  logic [lg_max_cfgs_p-1:0]     cfg_i,
    input  logic [field_idx_width_p-1:0] field_i,
    output logic [data_width_p-1:0]      data_o,
    output logic                         err_o
);

    logic                                 w_cfg_bad;
    logic                                 w_field_bad;
    bp_proc_param_s                       w_params;
    logic [bp_cfg_max_field_width_gp-1:0] w_value;

    assign w_cfg_bad   = (cfg_i == '0) || (32'(cfg_i) >= num_cfgs_p);
    assign w_field_bad = 32'(field_i) >= num_fields_p;
    assign w_params    = bp_cfg_lookup(32'(cfg_i));
    assign w_value     = bp_cfg_field_get(w_params, bp_cfg_field_idx_width_gp'(field_i));

    assign err_o  = w_cfg_bad | w_field_bad;
    assign data_o = err_o ? '0 : data_width_p'(w_value);

endmodule
`default_nettype wire

// File: rtl/bp_cfg_param_responder.sv
`default_nettype none
// ============================================================================
// Module      : bp_cfg_param_responder
// Description : Ready/valid responder for single-field reads and full dumps.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_cfg_param_responder
    import bp_common_aviary_pkg::*;
#(
    parameter int unsigned max_cfgs_p        = 128,
    parameter int unsigned num_cfgs_p        = 10,
    parameter int unsigned num_fields_p      = 41,
    parameter int unsigned field_idx_width_p = 6,
    parameter int unsigned data_width_p      = 32,
    parameter int unsigned lg_max_cfgs_p     = $clog2(max_cfgs_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         req_v_i,
    output logic                         req_ready_o,
    input  logic [lg_max_cfgs_p-1:0]     req_cfg_i,
    input  logic [field_idx_width_p-1:0] req_field_i,
    input  logic                         req_dump_i,
    output logic                         resp_v_o,
    input  logic                         resp_ready_i,
    output logic [data_width_p-1:0]      resp_data_o,
    output logic [field_idx_width_p-1:0] resp_field_o,
    output logic                         resp_err_o,
    output logic                         resp_last_o,
    output logic                         busy_o
);

    localparam logic [1:0] e_idle = 2'd0;
    localparam logic [1:0] e_resp = 2'd1;
    localparam logic [1:0] e_dump = 2'd2;

    localparam logic [field_idx_width_p-1:0] c_last_idx = field_idx_width_p'(num_fields_p - 1);

    if (bp_cfg_max_field_width_gp > data_width_p) begin : g_width_check
        $error("bp_cfg_param_responder: a config field is wider than data_width_p");
    end
    if (num_fields_p != num_cfg_fields_gp) begin : g_field_count_check
        $error("bp_cfg_param_responder: num_fields_p does not match bp_proc_param_s");
    end

    logic [1:0]                   r_state;
    logic [lg_max_cfgs_p-1:0]     r_cfg;
    logic [field_idx_width_p-1:0] r_cnt;
    logic                         r_resp_v;
    logic [data_width_p-1:0]      r_resp_data;
    logic [field_idx_width_p-1:0] r_resp_field;
    logic                         r_resp_err;
    logic                         r_resp_last;

    logic                         w_ready;
    logic                         w_req_acc;
    logic                         w_resp_hs;
    logic [field_idx_width_p-1:0] w_cnt_nxt;
    logic [lg_max_cfgs_p-1:0]     w_mux_cfg;
    logic [field_idx_width_p-1:0] w_mux_field;
    logic [data_width_p-1:0]      w_mux_data;
    logic                         w_mux_err;

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            e_idle:  w_ready = ~r_resp_v | resp_ready_i;
            e_resp:  w_ready = resp_ready_i;
            default: w_ready = 1'b0;
        endcase
    end

    // Gated with reset so nothing is accepted while the block is held in reset.
    assign req_ready_o = reset_n_i & w_ready;
    assign w_req_acc   = req_v_i & req_ready_o;
    assign w_resp_hs   = r_resp_v & resp_ready_i;
    assign w_cnt_nxt   = r_cnt + field_idx_width_p'(1);

    // One lookup shared by both paths: a dump in progress owns it, otherwise the request does.
    assign w_mux_cfg   = (r_state == e_dump) ? r_cfg : req_cfg_i;
    assign w_mux_field = (r_state == e_dump) ? w_cnt_nxt : (req_dump_i ? '0 : req_field_i);

    bp_cfg_field_mux #(
        .num_cfgs_p        (num_cfgs_p),
        .num_fields_p      (num_fields_p),
        .lg_max_cfgs_p     (lg_max_cfgs_p),
        .field_idx_width_p (field_idx_width_p),
        .data_width_p      (data_width_p)
    ) u_field_mux (
        .cfg_i   (w_mux_cfg),
        .field_i (w_mux_field),
        .data_o  (w_mux_data),
        .err_o   (w_mux_err)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= e_idle;
            r_cfg        <= '0;
            r_cnt        <= '0;
            r_resp_v     <= 1'b0;
            r_resp_data  <= '0;
            r_resp_field <= '0;
            r_resp_err   <= 1'b0;
            r_resp_last  <= 1'b0;
        end else begin
            case (r_state)
                e_dump: begin
                    if (w_resp_hs) begin
                        if (r_cnt == c_last_idx) begin
                            r_resp_v <= 1'b0;
                            r_state  <= e_idle;
                        end else begin
                            r_cnt        <= w_cnt_nxt;
                            r_resp_data  <= w_mux_data;
                            r_resp_err   <= w_mux_err;
                            r_resp_field <= w_cnt_nxt;
                            r_resp_last  <= (w_cnt_nxt == c_last_idx);
                        end
                    end
                end
                default: begin
                    if (w_req_acc) begin
                        r_resp_v    <= 1'b1;
                        r_resp_data <= w_mux_data;
                        r_resp_err  <= w_mux_err;
                        if (req_dump_i) begin
                            r_cfg        <= req_cfg_i;
                            r_cnt        <= '0;
                            r_resp_field <= '0;
                            r_resp_last  <= (c_last_idx == '0);
                            r_state      <= e_dump;
                        end else begin
                            r_resp_field <= req_field_i;
                            r_resp_last  <= 1'b1;
                            r_state      <= e_resp;
                        end
                    end else if (w_resp_hs) begin
                        r_resp_v <= 1'b0;
                        r_state  <= e_idle;
                    end
                end
            endcase
        end
    end

    assign resp_v_o     = r_resp_v;
    assign resp_data_o  = r_resp_data;
    assign resp_field_o = r_resp_field;
    assign resp_err_o   = r_resp_err;
    assign resp_last_o  = r_resp_last;
    assign busy_o       = (r_state != e_idle);

endmodule
`default_nettype wire

// File: tb/tb_bp_cfg_param_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_cfg_param_responder
// Description : Scoreboard bench for the config parameter responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_cfg_param_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_v_i, req_ready_o, req_dump_i;
    logic [6:0]  req_cfg_i;
    logic [5:0]  req_field_i;
    logic        resp_v_o, resp_ready_i, resp_err_o, resp_last_o, busy_o;
    logic [31:0] resp_data_o;
    logic [5:0]  resp_field_o;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  field;
        logic        err;
        logic        last;
        logic        dump;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;
    int   dump_beats = 0;
    int   dump_exp [41];
    logic dump_err = 1'b0;

    // Hand-computed contents of config 9, fields 0..40.
    int cfg9_tbl [41] = '{2, 4, 1, 1, 0, 0, 0, 0, 0, 0, 8, 16, 39, 40, 10, 39, 10, 6, 9, 2,
                          8, 64, 512, 256, 8, 0, 8, 128, 2, 3, 0, 32, 64, 2, 4, 0, 16, 64, 2, 1, 4};

    always #5 clk = ~clk;

    bp_cfg_param_responder dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .req_v_i      (req_v_i),
        .req_ready_o  (req_ready_o),
        .req_cfg_i    (req_cfg_i),
        .req_field_i  (req_field_i),
        .req_dump_i   (req_dump_i),
        .resp_v_o     (resp_v_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .resp_field_o (resp_field_o),
        .resp_err_o   (resp_err_o),
        .resp_last_o  (resp_last_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response-ready driver: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        resp_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       resp_ready_i = 1'b1;
                1:       resp_ready_i = 1'($urandom_range(0, 1));
                default: resp_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: compares every presented beat against the scoreboard head.
    initial begin
        logic acc_prev;
        exp_t e;
        acc_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                acc_prev = 1'b0;
            end else begin
                if (acc_prev) chk("latency", 64'(resp_v_o), 64'd1);
                if (resp_v_o) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got resp_v_o=1 field=%0d, required no response",
                                 resp_field_o);
                    end else begin
                        e = q[0];
                        chk("resp", 64'({resp_err_o, resp_last_o, resp_field_o, resp_data_o}),
                                    64'({e.err, e.last, e.field, e.data}));
                        chk("busy_while_valid", 64'(busy_o), 64'd1);
                        if (e.dump) chk("req_ready_in_dump", 64'(req_ready_o), 64'd0);
                        if (resp_ready_i) begin
                            void'(q.pop_front());
                            if (e.dump) dump_beats++;
                        end
                    end
                end
                acc_prev = req_v_i & req_ready_o;
            end
        end
    end

    task automatic send_req(input logic [6:0] cfg, input logic [5:0] field, input logic dump,
                            input logic [31:0] exp_data, input logic exp_err);
        bit ok;
        ok = 1'b0;
        req_v_i = 1'b1; req_cfg_i = cfg; req_field_i = field; req_dump_i = dump;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: got no accept in 50 cycles, required accept (cfg=%0d)", cfg);
        end else if (dump) begin
            for (int k = 0; k < 41; k++)
                q.push_back('{data: dump_err ? 32'd0 : 32'(dump_exp[k]), field: 6'(k),
                              err: dump_err, last: (k == 40), dump: 1'b1});
        end else begin
            q.push_back('{data: exp_data, field: field, err: exp_err, last: 1'b1, dump: 1'b0});
        end
        @(posedge clk);
        #1;
        req_v_i = 1'b0; req_dump_i = 1'b0; req_cfg_i = 7'd0; req_field_i = 6'd0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        chk("drain", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        req_v_i = 1'b0; req_cfg_i = 7'd0; req_field_i = 6'd0; req_dump_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 64'({resp_v_o, resp_data_o, resp_field_o, resp_err_o, resp_last_o,
                                busy_o, req_ready_o}), 64'd0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single reads, including a back-to-back pair with no bubble.
        send_req(7'd2, 6'd20, 1'b0, 32'd4, 1'b0);
        wait_drain();
        send_req(7'd5, 6'd25, 1'b0, 32'd1, 1'b0);
        send_req(7'd3, 6'd39, 1'b0, 32'd2, 1'b0);
        send_req(7'd6, 6'd22, 1'b0, 32'd256, 1'b0);
        send_req(7'd7, 6'd12, 1'b0, 32'd48, 1'b0);
        send_req(7'd9, 6'd40, 1'b0, 32'd4, 1'b0);
        send_req(7'd4, 6'd10, 1'b0, 32'd4, 1'b0);
        wait_drain();

        // Range errors on config id and field index.
        send_req(7'd0, 6'd0, 1'b0, 32'd0, 1'b1);
        send_req(7'd9, 6'd41, 1'b0, 32'd0, 1'b1);
        send_req(7'd12, 6'd5, 1'b0, 32'd0, 1'b1);
        send_req(7'd10, 6'd0, 1'b0, 32'd0, 1'b1);
        send_req(7'd1, 6'd63, 1'b0, 32'd0, 1'b1);
        wait_drain();

        // Dump of config 9 with a randomly toggling consumer.
        rdy_mode = 1;
        foreach (dump_exp[k]) dump_exp[k] = cfg9_tbl[k];
        dump_err = 1'b0;
        dump_beats = 0;
        send_req(7'd9, 6'd7, 1'b1, 32'd0, 1'b0);
        wait_drain();
        chk("dump_beat_count", 64'(dump_beats), 64'd41);
        rdy_mode = 0;

        // Dump of an invalid config: 41 error beats.
        foreach (dump_exp[k]) dump_exp[k] = 0;
        dump_err = 1'b1;
        send_req(7'd0, 6'd3, 1'b1, 32'd0, 1'b0);
        wait_drain();

        // Stalled single read holds its response.
        rdy_mode = 2;
        send_req(7'd1, 6'd13, 1'b0, 32'd40, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready_busy_v", 64'({req_ready_o, busy_o, resp_v_o}), 64'b011);
        end
        rdy_mode = 0;
        wait_drain();

        // Reset in the middle of a dump at beat 17.
        foreach (dump_exp[k]) dump_exp[k] = cfg9_tbl[k];
        dump_err = 1'b0;
        dump_beats = 0;
        send_req(7'd9, 6'd0, 1'b1, 32'd0, 1'b0);
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(posedge clk);
                #2;
                if (dump_beats == 17) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("reach_beat17", 64'(hit), 64'd1);
        end
        chk("beat17_field", 64'(resp_field_o), 64'd17);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({resp_v_o, resp_data_o, resp_field_o, resp_err_o,
                                        resp_last_o, busy_o, req_ready_o}), 64'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 64'({req_ready_o, busy_o, resp_v_o}), 64'b100);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1;
        send_req(7'd8, 6'd11, 1'b0, 32'd32, 1'b0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
